// File: rtl/imp_serializer.sv
// imp_serializer
//   Consumes one per-variable result vector from the clause evaluation stage
//   and serialises its clause-implied assignments, lowest index first, to the
//   BCP/decision stage. A vector containing any conflicting variable produces
//   a single conflict event instead of implications.
//
//   Handshakes (both valid/ready): a transfer happens on a rising clk edge
//   where valid and ready are both high. The producer holds a valid request
//   and its payload unchanged until the transfer. The consumer may drop ready
//   at any time.
//
//   Ports
//     clk, rst          clock, asynchronous active-high reset
//     flush_i           synchronous abort (backtrack), returns to IDLE
//     valid_i/ready_o   input vector handshake; ready_o high only in IDLE
//     var_value_i       NUM_VARS x 3 bits: {implied, value[1:0]} per variable
//                       value 00 free, 01 true, 10 false, 11 conflict
//     imp_valid_o/imp_ready_i  implication handshake
//     imp_var_o, imp_value_o   implied variable index and value (01/10)
//     conflict_o        one-cycle pulse when the vector held a conflict
//     conflict_var_o    lowest conflicting index, held until next accept
//     done_o            one-cycle pulse when the vector is finished
//     imp_count_o       implications emitted for the current/last vector
//     fsm_state_o       current FSM state (debug)
//   Optional build macro IMP_SERIALIZER_STATS_EN adds saturating counters
//     stat_imps_o, stat_conflicts_o (cleared only by rst).
module imp_serializer #(
  parameter int NUM_VARS = 8,
  localparam int VAR_IDX_W = $clog2(NUM_VARS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [NUM_VARS*3-1:0] var_value_i,
  output logic                  imp_valid_o,
  input  logic                  imp_ready_i,
  output logic [VAR_IDX_W-1:0]  imp_var_o,
  output logic [1:0]            imp_value_o,
  output logic                  conflict_o,
  output logic [VAR_IDX_W-1:0]  conflict_var_o,
  output logic                  done_o,
  output logic [VAR_IDX_W:0]    imp_count_o,
`ifdef IMP_SERIALIZER_STATS_EN
  output logic [15:0]           stat_imps_o,
  output logic [15:0]           stat_conflicts_o,
`endif
  output logic [1:0]            fsm_state_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_EMIT     = 2'd1;
  localparam logic [1:0] S_CONFLICT = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]            state_q;
  logic [NUM_VARS-1:0]   pending_q;
  logic [NUM_VARS*2-1:0] vals_q;
  logic [VAR_IDX_W-1:0]  cvar_q;
  logic [VAR_IDX_W:0]    count_q;

  // Decode of the incoming vector.
  logic [NUM_VARS-1:0]   in_pend;
  logic [NUM_VARS-1:0]   in_cmask;
  logic [NUM_VARS*2-1:0] in_vals;
  logic [VAR_IDX_W-1:0]  in_cvar;

  always_comb begin
    in_pend  = '0;
    in_cmask = '0;
    in_vals  = '0;
    in_cvar  = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      in_vals[2*i +: 2] = var_value_i[3*i +: 2];
      in_pend[i]  = var_value_i[3*i+2] &&
                    (var_value_i[3*i +: 2] == 2'b01 || var_value_i[3*i +: 2] == 2'b10);
      in_cmask[i] = (var_value_i[3*i +: 2] == 2'b11);
    end
    // Descending scan so the lowest conflicting index wins.
    for (int i = NUM_VARS - 1; i >= 0; i--) begin
      if (in_cmask[i]) in_cvar = VAR_IDX_W'(i);
    end
  end

  // Lowest pending index and the mask left once it is consumed.
  logic [VAR_IDX_W-1:0] sel_idx;
  logic [NUM_VARS-1:0]  sel_onehot;
  logic [NUM_VARS-1:0]  pend_next;

  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = NUM_VARS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx    = VAR_IDX_W'(i);
        sel_onehot = NUM_VARS'(1) << i;
      end
    end
    pend_next = pending_q & ~sel_onehot;
  end

  logic accept;
  logic imp_fire;
  assign accept   = valid_i && (state_q == S_IDLE) && !flush_i;
  assign imp_fire = (state_q == S_EMIT) && imp_ready_i && !flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      vals_q    <= '0;
      cvar_q    <= '0;
      count_q   <= '0;
    end else if (flush_i) begin
      // Abort wins over everything, including a same-cycle accept.
      state_q   <= S_IDLE;
      pending_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            pending_q <= in_pend;
            vals_q    <= in_vals;
            cvar_q    <= in_cvar;
            count_q   <= '0;
            if (in_cmask != '0)     state_q <= S_CONFLICT;
            else if (in_pend != '0) state_q <= S_EMIT;
            else                    state_q <= S_DONE;
          end
        end
        S_EMIT: begin
          if (imp_fire) begin
            pending_q <= pend_next;
            count_q   <= count_q + 1'b1;
            if (pend_next == '0) state_q <= S_DONE;
          end
        end
        S_CONFLICT: begin
          pending_q <= '0;
          state_q   <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o        = (state_q == S_IDLE);
  assign imp_valid_o    = (state_q == S_EMIT);
  assign imp_var_o      = sel_idx;
  assign imp_value_o    = vals_q[2*sel_idx +: 2];
  assign conflict_o     = (state_q == S_CONFLICT);
  assign conflict_var_o = cvar_q;
  assign done_o         = (state_q == S_DONE);
  assign imp_count_o    = count_q;
  assign fsm_state_o    = state_q;

`ifdef IMP_SERIALIZER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_imps_o      <= '0;
      stat_conflicts_o <= '0;
    end else begin
      if (imp_fire && stat_imps_o != 16'hFFFF)
        stat_imps_o <= stat_imps_o + 16'd1;
      if (conflict_o && stat_conflicts_o != 16'hFFFF)
        stat_conflicts_o <= stat_conflicts_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imp_serializer.sv
module tb_imp_serializer;
  localparam int NV = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [NV*3-1:0] var_value_i = '0;
  logic          imp_valid_o;
  logic          imp_ready_i = 1'b0;
  logic [IW-1:0] imp_var_o;
  logic [1:0]    imp_value_o;
  logic          conflict_o;
  logic [IW-1:0] conflict_var_o;
  logic          done_o;
  logic [IW:0]   imp_count_o;
  logic [1:0]    fsm_state_o;
`ifdef IMP_SERIALIZER_STATS_EN
  logic [15:0]   stat_imps_o;
  logic [15:0]   stat_conflicts_o;
`endif

  int errors = 0;
  int checks = 0;

  // clock / reset
  always #5 clk = ~clk;

  imp_serializer #(.NUM_VARS(NV)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .var_value_i(var_value_i),
    .imp_valid_o(imp_valid_o), .imp_ready_i(imp_ready_i),
    .imp_var_o(imp_var_o), .imp_value_o(imp_value_o),
    .conflict_o(conflict_o), .conflict_var_o(conflict_var_o),
    .done_o(done_o), .imp_count_o(imp_count_o),
`ifdef IMP_SERIALIZER_STATS_EN
    .stat_imps_o(stat_imps_o), .stat_conflicts_o(stat_conflicts_o),
`endif
    .fsm_state_o(fsm_state_o)
  );

  // Inputs change on negedge; outputs are checked on negedge (after the
  // preceding posedge has settled).
  task automatic drive_vec(input logic [NV*3-1:0] v);
    @(negedge clk);
    valid_i     = 1'b1;
    var_value_i = v;
    @(negedge clk);
    valid_i     = 1'b0;
    var_value_i = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    checks++; if (imp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_imp_valid got=%b exp=0", imp_valid_o); end
    checks++; if (conflict_o !== 1'b0) begin errors++; $display("FAIL reset_conflict got=%b exp=0", conflict_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_o); end
    checks++; if (imp_count_o !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", imp_count_o); end
    checks++; if (fsm_state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", fsm_state_o); end
  endtask

  task automatic test_emit;
    logic [NV*3-1:0] v;
    v = '0;
    v[11:9]  = 3'b101;  // var3 implied true
    v[17:15] = 3'b110;  // var5 implied false
    v[5:3]   = 3'b100;  // var1 implied but free: ignored
    v[8:6]   = 3'b010;  // var2 plain assignment: not emitted
    imp_ready_i = 1'b1;
    drive_vec(v);
    checks++; if (imp_valid_o !== 1'b1 || imp_var_o !== 3'd3 || imp_value_o !== 2'b01) begin errors++;
      $display("FAIL emit_first got v=%b var=%0d val=%b exp v=1 var=3 val=01", imp_valid_o, imp_var_o, imp_value_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL emit_busy_ready got=%b exp=0", ready_o); end
    @(negedge clk);
    checks++; if (imp_valid_o !== 1'b1 || imp_var_o !== 3'd5 || imp_value_o !== 2'b10) begin errors++;
      $display("FAIL emit_second got v=%b var=%0d val=%b exp v=1 var=5 val=10", imp_valid_o, imp_var_o, imp_value_o); end
    checks++; if (imp_count_o !== 4'd1) begin errors++; $display("FAIL emit_count_mid got=%0d exp=1", imp_count_o); end
    @(negedge clk);
    checks++; if (done_o !== 1'b1 || imp_valid_o !== 1'b0) begin errors++;
      $display("FAIL emit_done got done=%b v=%b exp done=1 v=0", done_o, imp_valid_o); end
    checks++; if (imp_count_o !== 4'd2) begin errors++; $display("FAIL emit_count got=%0d exp=2", imp_count_o); end
    @(negedge clk);
    checks++; if (done_o !== 1'b0 || ready_o !== 1'b1) begin errors++;
      $display("FAIL emit_idle got done=%b ready=%b exp done=0 ready=1", done_o, ready_o); end
  endtask

  task automatic test_conflict;
    logic [NV*3-1:0] v;
    v = '0;
    v[5:3]   = 3'b110;  // var1 implied
    v[11:9]  = 3'b111;  // var3 conflict
    v[17:15] = 3'b110;  // var5 implied
    v[20:18] = 3'b011;  // var6 conflict without implied flag, higher index
    imp_ready_i = 1'b1;
    drive_vec(v);
    checks++; if (conflict_o !== 1'b1 || conflict_var_o !== 3'd3) begin errors++;
      $display("FAIL conflict_pulse got c=%b var=%0d exp c=1 var=3", conflict_o, conflict_var_o); end
    checks++; if (imp_valid_o !== 1'b0) begin errors++; $display("FAIL conflict_no_imp got=%b exp=0", imp_valid_o); end
    @(negedge clk);
    checks++; if (done_o !== 1'b1 || conflict_o !== 1'b0 || imp_valid_o !== 1'b0) begin errors++;
      $display("FAIL conflict_done got done=%b c=%b v=%b exp 1 0 0", done_o, conflict_o, imp_valid_o); end
    checks++; if (imp_count_o !== 4'd0) begin errors++; $display("FAIL conflict_count got=%0d exp=0", imp_count_o); end
    checks++; if (conflict_var_o !== 3'd3) begin errors++; $display("FAIL conflict_var_hold got=%0d exp=3", conflict_var_o); end
    @(negedge clk);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL conflict_idle got=%b exp=1", ready_o); end
  endtask

  task automatic test_stall;
    logic [NV*3-1:0] v;
    v = '0;
    v[2:0]   = 3'b101;  // var0 true
    v[23:21] = 3'b110;  // var7 false (top index)
    imp_ready_i = 1'b0;
    drive_vec(v);
    for (int c = 0; c < 3; c++) begin
      checks++; if (imp_valid_o !== 1'b1 || imp_var_o !== 3'd0 || imp_value_o !== 2'b01) begin errors++;
        $display("FAIL stall_hold cyc=%0d got v=%b var=%0d val=%b exp v=1 var=0 val=01", c, imp_valid_o, imp_var_o, imp_value_o); end
      if (c < 2) @(negedge clk);
    end
    imp_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (imp_valid_o !== 1'b1 || imp_var_o !== 3'd7 || imp_value_o !== 2'b10) begin errors++;
      $display("FAIL stall_var7 got v=%b var=%0d val=%b exp v=1 var=7 val=10", imp_valid_o, imp_var_o, imp_value_o); end
    @(negedge clk);
    checks++; if (done_o !== 1'b1 || imp_count_o !== 4'd2) begin errors++;
      $display("FAIL stall_done got done=%b cnt=%0d exp done=1 cnt=2", done_o, imp_count_o); end
    @(negedge clk);
  endtask

  task automatic test_no_emit;
    logic [NV*3-1:0] v;
    for (int i = 0; i < NV; i++) v[3*i +: 3] = (i % 2 == 0) ? 3'b001 : 3'b100;
    drive_vec(v);
    checks++; if (done_o !== 1'b1 || imp_valid_o !== 1'b0 || ready_o !== 1'b0) begin errors++;
      $display("FAIL noemit_done got done=%b v=%b rdy=%b exp 1 0 0", done_o, imp_valid_o, ready_o); end
    checks++; if (imp_count_o !== 4'd0) begin errors++; $display("FAIL noemit_count got=%0d exp=0", imp_count_o); end
    @(negedge clk);
    checks++; if (ready_o !== 1'b1 || done_o !== 1'b0) begin errors++;
      $display("FAIL noemit_ready got rdy=%b done=%b exp 1 0", ready_o, done_o); end
  endtask

  task automatic test_flush;
    logic [NV*3-1:0] v;
    v = '0;
    v[8:6]   = 3'b101;  // var2
    v[14:12] = 3'b110;  // var4
    v[20:18] = 3'b101;  // var6
    imp_ready_i = 1'b1;
    drive_vec(v);
    checks++; if (imp_var_o !== 3'd2) begin errors++; $display("FAIL flush_first got=%0d exp=2", imp_var_o); end
    @(negedge clk);
    checks++; if (imp_var_o !== 3'd4 || imp_count_o !== 4'd1) begin errors++;
      $display("FAIL flush_second got var=%0d cnt=%0d exp var=4 cnt=1", imp_var_o, imp_count_o); end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checks++; if (imp_valid_o !== 1'b0 || ready_o !== 1'b1 || done_o !== 1'b0 || conflict_o !== 1'b0) begin errors++;
      $display("FAIL flush_idle got v=%b rdy=%b done=%b c=%b exp 0 1 0 0", imp_valid_o, ready_o, done_o, conflict_o); end
    checks++; if (imp_count_o !== 4'd1) begin errors++; $display("FAIL flush_count got=%0d exp=1", imp_count_o); end
    @(negedge clk);
    checks++; if (done_o !== 1'b0 || imp_valid_o !== 1'b0) begin errors++;
      $display("FAIL flush_quiet got done=%b v=%b exp 0 0", done_o, imp_valid_o); end
    // Same-cycle accept is dropped by flush.
    valid_i = 1'b1; var_value_i = v; flush_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; var_value_i = '0; flush_i = 1'b0;
    checks++; if (ready_o !== 1'b1 || imp_valid_o !== 1'b0 || imp_count_o !== 4'd1) begin errors++;
      $display("FAIL flush_drop got rdy=%b v=%b cnt=%0d exp 1 0 1", ready_o, imp_valid_o, imp_count_o); end
  endtask

  task automatic test_reset_mid_emit;
    logic [NV*3-1:0] v;
    v = '0;
    v[2:0] = 3'b101;
    v[5:3] = 3'b110;
    imp_ready_i = 1'b1;
    drive_vec(v);
    @(negedge clk);  // one implication taken, still in EMIT
    checks++; if (imp_valid_o !== 1'b1 || imp_count_o !== 4'd1) begin errors++;
      $display("FAIL rstmid_pre got v=%b cnt=%0d exp 1 1", imp_valid_o, imp_count_o); end
    #1 rst = 1'b1;
    #1;
    checks++; if (imp_valid_o !== 1'b0 || ready_o !== 1'b1 || imp_count_o !== 4'd0 || conflict_var_o !== 3'd0) begin errors++;
      $display("FAIL rstmid_async got v=%b rdy=%b cnt=%0d cvar=%0d exp 0 1 0 0", imp_valid_o, ready_o, imp_count_o, conflict_var_o); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (done_o !== 1'b0 || imp_valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++;
      $display("FAIL rstmid_after got done=%b v=%b rdy=%b exp 0 0 1", done_o, imp_valid_o, ready_o); end
  endtask

  initial begin
    test_reset();
    test_emit();
    test_conflict();
    test_stall();
    test_no_emit();
    test_flush();
    test_reset_mid_emit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imp_serializer.md
Name: imp_serializer

Overview:
- Sits directly downstream of the clause evaluation stage and consumes its per-variable result vector (var_value_o).
- Each accepted vector is scanned for conflicts and clause-implied assignments.
- Implied assignments are emitted one per handshake, in ascending variable index, to the BCP/decision stage.
- A conflict is reported as a single event instead of emitting implications.

Parameters:
- NUM_VARS, 8, number of variables in the vector; must be ≥2.
- VAR_IDX_W, $clog2(NUM_VARS), width of a variable index (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous abort (backtrack); returns block to IDLE.
- valid_i  in  1  var_value_i valid.
- ready_o  out  1  block can accept a vector.
- var_value_i  in  NUM_VARS*3  variable i at bits [3i+2:3i]; bit2 = implied flag; bits[1:0]: 00 free, 01 true, 10 false, 11 conflict.
- imp_valid_o  out  1  implication available.
- imp_ready_i  in  1  consumer accepts implication.
- imp_var_o  out  VAR_IDX_W  index of implied variable.
- imp_value_o  out  2  value of implied variable (01 or 10).
- conflict_o  out  1  one-cycle pulse: vector contained a conflict.
- conflict_var_o  out  VAR_IDX_W  lowest conflicting index; held until next accept.
- done_o  out  1  one-cycle pulse: vector fully processed.
- imp_count_o  out  VAR_IDX_W+1  implications emitted for current/last vector.

Behaviour:
- Reset: all outputs 0, except ready_o=1; FSM in IDLE; pending mask 0.
- Accept: valid_i && ready_o on a rising edge.
  - Latches pending[i] = bit2 && bits[1:0] ∈ {01,10}.
  - Latches conflict mask cmask[i] = (bits[1:0] == 11), regardless of bit2.
  - Latches the values; clears imp_count_o.
- ready_o = 1 only in IDLE.
- States:
  - IDLE: on accept, if cmask≠0 → CONFLICT; else if pending≠0 → EMIT; else → DONE.
  - EMIT:
    - imp_valid_o=1; imp_var_o = lowest set index of pending; imp_value_o = its latched value.
    - On imp_ready_i: clear that bit and imp_count_o+=1.
    - If it was the last bit → DONE, else stay in EMIT.
    - Outputs are stable while imp_ready_i=0.
  - CONFLICT: conflict_o=1 for one cycle; conflict_var_o = lowest cmask index; pending discarded; → DONE.
  - DONE: done_o=1 for one cycle; → IDLE.
- Latency: first imp_valid_o is in the cycle after accept, registered. Back-to-back ready gives one implication per cycle.
- Minimum occupancy per vector: accept + k emit cycles + 1 DONE cycle; + CONFLICT cycle if a conflict is present.
- Boundary conditions:
  - bit2=1 with value 00 is ignored.
  - bit2=0 with value 01/10 is an ordinary assignment, not emitted.
  - Index NUM_VARS-1 is emitted normally.
  - Conflict takes priority over any number of implications.
- flush_i:
  - Has priority over every transition, including a same-cycle accept, which is dropped.
  - Next state IDLE; pending and cmask cleared.
  - imp_valid_o drops the next cycle; no done_o or conflict_o pulse.
  - imp_count_o is kept.
- rst mid-EMIT: immediate return to reset values.

Optional Feature:
- IMP_SERIALIZER_STATS_EN defined adds two outputs, each saturating at all-ones and cleared only by rst:
  - stat_imps_o [15:0]: cumulative accepted implications.
  - stat_conflicts_o [15:0]: cumulative conflict pulses.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle → ready_o=1, imp_valid_o=0, conflict_o=0, done_o=0, imp_count_o=0.
- Vector with var3=3'b101, var5=3'b110, others 0; imp_ready_i=1 → (var 3, value 01) then (var 5, value 10) on consecutive cycles; done_o next cycle; imp_count_o=2.
- Vector with var1=3'b110, var3=3'b111, var5=3'b110 → no imp_valid_o; conflict_o pulse with conflict_var_o=3; then done_o; imp_count_o=0.
- Vector with var0=3'b101, var7=3'b110; imp_ready_i low for 3 cycles → var 0 held stable for 3 cycles; then var 0, then var 7 emitted.
- All vars 3'b001 or 3'b100 → no emission; done_o the cycle after accept; ready_o=1 the following cycle.
- flush_i asserted during EMIT after first of three implications → imp_valid_o=0 next cycle, ready_o=1, no done_o, imp_count_o=1.
